// File: rtl/aes_128_stream_ctrl_if.sv
// ----------------------------------------------------------------------------
// aes_128_stream_ctrl_if : upstream/downstream block handshakes of the AES ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface aes_128_stream_ctrl_if #(
  parameter int TAG_W = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     in_state;
  logic [127:0]     in_key;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_data;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_state, in_key, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );

  modport master (
    output in_valid, in_state, in_key, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );
endinterface

`default_nettype wire

// File: rtl/aes_128_stream_ctrl.sv
// ----------------------------------------------------------------------------
// aes_128_stream_ctrl : credit-based flow control around a non-stallable AES core
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module aes_128_stream_ctrl #(
  parameter int LATENCY = 21,
  parameter int DEPTH   = 32,
  parameter int TAG_W   = 8
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  aes_128_stream_ctrl_if.slave   bus,
  output logic [127:0]           core_state,
  output logic [127:0]           core_key,
  input  wire logic [127:0]      core_out
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = 128 + TAG_W;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [PW-1:0] C_LAST  = PW'(DEPTH - 1);

  logic               r_run;
  logic [CW-1:0]      r_credits;
  logic [LATENCY-1:0] r_vpipe;
  logic [TAG_W-1:0]   r_tpipe [LATENCY];
  logic [EW-1:0]      r_mem   [DEPTH];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic               r_out_valid;
  logic [127:0]       r_out_data;
  logic [TAG_W-1:0]   r_out_tag;

  logic               w_issue;
  logic               w_pop;
  logic               w_wr;
  logic [EW-1:0]      w_wdata;
  logic [CW-1:0]      w_count_nxt;
  logic [PW-1:0]      w_rd_nxt;
  logic [EW-1:0]      w_head_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == C_LAST) ? '0 : p + PW'(1);
  endfunction

  assign core_state    = bus.in_state;
  assign core_key      = bus.in_key;
  // r_run keeps in_ready low while reset is held even though credits are full
  assign bus.in_ready  = r_run && (r_credits != '0);
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_tag   = r_out_tag;

  assign w_issue = bus.in_valid && bus.in_ready;
  assign w_pop   = r_out_valid && bus.out_ready;
  assign w_wr    = r_vpipe[LATENCY-1];
  assign w_wdata = {core_out, r_tpipe[LATENCY-1]};

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr && !w_pop)
      w_count_nxt = r_count + CW'(1);
    else if (!w_wr && w_pop)
      w_count_nxt = r_count - CW'(1);
    w_rd_nxt = w_pop ? ptr_inc(r_rd_ptr) : r_rd_ptr;
    // an entry written into an empty (or emptying) FIFO becomes the new head directly
    if ((r_count == '0) || (w_pop && (r_count == CW'(1))))
      w_head_nxt = w_wdata;
    else
      w_head_nxt = r_mem[w_rd_nxt];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run     <= 1'b0;
      r_credits <= C_DEPTH;
      r_vpipe   <= '0;
      for (int i = 0; i < LATENCY; i++)
        r_tpipe[i] <= '0;
    end else begin
      r_run      <= 1'b1;
      r_vpipe[0] <= w_issue;
      r_tpipe[0] <= w_issue ? bus.in_tag : '0;
      for (int i = 1; i < LATENCY; i++) begin
        r_vpipe[i] <= r_vpipe[i-1];
        r_tpipe[i] <= r_tpipe[i-1];
      end
      case ({w_issue, w_pop})
        2'b10:   r_credits <= r_credits - CW'(1);
        2'b01:   r_credits <= r_credits + CW'(1);
        default: r_credits <= r_credits;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_wr_ptr] <= w_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_tag   <= '0;
    end else begin
      if (w_wr)
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      r_rd_ptr    <= w_rd_nxt;
      r_count     <= w_count_nxt;
      r_out_valid <= (w_count_nxt != '0);
      if (w_count_nxt != '0)
        {r_out_data, r_out_tag} <= w_head_nxt;
    end
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_wr && (r_count == C_DEPTH)));
  a_credit_range: assert property (@(posedge clk) disable iff (!rst_n)
    r_credits <= C_DEPTH);
`endif

endmodule

`default_nettype wire
